instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline: initiator side of the instruction-memory read interface.
- Owns the PC and drives a byte address to the asynchronous-read instruction memory, which is word-indexed by Address[31:2].
- Latches the returned word into the IF/ID pipeline register.
- Handles hazard stalls, branch/jump redirects and a halt instruction.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- HALT_INSTR, 32'hFC000000, instruction word that stops fetching.
- NOP_INSTR, 32'h00000000, word loaded into IF/ID for a bubble.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals the PC combinationally.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- stall_if  in  1  hazard stall: hold the PC and IF/ID.
- redirect_valid  in  1  branch taken or jump: load redirect_pc and flush IF/ID.
- redirect_pc  in  32  redirect target byte address.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc  out  32  IF/ID PC of that instruction.
- if_id_pc_plus4  out  32  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction, not a bubble.
- halted  out  1  high while in HALT state.
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0.
- fetch_count  out  32  number of instructions latched valid into IF/ID; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset (reset=1 at an edge):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0.
  - halted=0, misalign_err=0, fetch_count=0, state=RUN.
  - Reset overrides every other input, including mid-stall and mid-redirect.
- imem_addr=pc at all times. The memory read is combinational, so the word for pc is captured at the same edge: zero-cycle fetch latency, one cycle to reach IF/ID.
- States are RUN and HALT. Per-edge priority: reset > redirect_valid > stall_if > normal.
- RUN, redirect_valid=1 (stall_if ignored):
  - pc = {redirect_pc[31:2],2'b00}.
  - IF/ID becomes a bubble: instr=NOP_INSTR, valid=0; if_id_pc and if_id_pc_plus4 hold.
  - The word at the old pc is discarded. fetch_count unchanged.
  - If redirect_pc[1:0]!=0, misalign_err is set to 1 and stays set until reset.
- RUN, stall_if=1, no redirect: pc and all IF/ID outputs hold; fetch_count holds.
- RUN, normal edge:
  - IF/ID loads instr=imem_instr, pc=pc, pc_plus4=pc+4, valid=1.
  - pc becomes pc+4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
  - fetch_count increments unless already saturated.
- RUN, normal edge with imem_instr==HALT_INSTR:
  - The halt word is latched valid into IF/ID and counted.
  - pc becomes pc+4, state becomes HALT, halted=1 on the following cycle.
  - A halt word seen during a stall or redirect edge has no effect.
- HALT state:
  - pc holds. The first edge in HALT loads a bubble (valid=0, NOP_INSTR); IF/ID then holds.
  - stall_if is ignored; fetch_count holds.
- HALT, redirect_valid=1: aligned pc loaded, state becomes RUN, halted drops on the next cycle, IF/ID stays a bubble.
- pc+4 uses 32-bit unsigned arithmetic with no carry out. Out-of-range addresses are the memory's concern; this block does not check them.

Decomposition:
- Shared package mips_pkg:
  - ifu_state_t enum {RUN, HALT}.
  - Constants HALT_INSTR_DEFAULT, NOP_INSTR, PC_STEP=4.
- One natural sub-module, fetch_pc_reg: the PC register plus next-PC mux (reset / redirect-aligned / hold / pc+4) and the misalign flag.
- IF/ID register, state machine and counter stay in the top module.

Test Plan:
1. Reset, then 4 free-running cycles on a memory holding 00221820, 00253822, 00329812, 000819E5 at byte addresses 0, 4, 8, 12. Required: imem_addr goes 0, 4, 8, 12; if_id_instr matches each word one cycle later with valid=1; fetch_count=4; if_id_pc_plus4 of the last instruction is 16.
2. stall_if high for 2 cycles while pc=8. Required: imem_addr stays 8, if_id_instr stays 00253822, fetch_count is unchanged; resume fetches 00329812.
3. redirect_valid and stall_if asserted together with redirect_pc=0x40 at pc=12. Required: next pc=0x40, if_id_valid=0 with if_id_instr=0; then the word at 0x40 is latched with if_id_pc=0x40.
4. Redirect to 0x42. Required: pc=0x40 and misalign_err=1; misalign_err stays 1 through later aligned redirects and drops only on reset.
5. HALT_INSTR placed at address 16. Required:
   - It is latched valid and counted; pc=20 and halted=1 on the next cycle, then a bubble.
   - pc holds at 20 for 10 cycles.
   - A redirect to 0 restores RUN and refetches 00221820.
6. Reset asserted mid-stall with pc=0x40 and misalign_err=1. Required: on the next edge pc=0, all IF/ID outputs cleared, misalign_err=0, fetch_count=0, halted=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ifu_state_t;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFC00_0000;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] PC_STEP            = 32'd4;

  // Instruction memory is word-indexed, so redirect targets drop their byte offset.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC selection (reset / redirect / hold / +4)
// and the sticky misaligned-redirect flag.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc,
  output logic        misalign_err
);

  logic [31:0] pc_d, pc_q;
  logic        misalign_d, misalign_q;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (redirect) begin
      pc_d = align_word(redirect_pc);
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (advance) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: drives the PC to async instruction memory and captures the
// returned word into the IF/ID register; handles stall, redirect and halt.
//
// state | meaning
// RUN   | fetching one word per unstalled cycle
// HALT  | halt word fetched; pc frozen, IF/ID bubble until a redirect
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  ifu_state_t  state_d, state_q;
  logic [31:0] instr_d, instr_q;
  logic [31:0] ifpc_d, ifpc_q;
  logic [31:0] pc4_d, pc4_q;
  logic        valid_d, valid_q;
  logic        halted_d, halted_q;
  logic [31:0] count_d, count_q;
  logic [31:0] pc;
  logic        advance;

  // Redirect wins over stall, and is honoured in both states.
  assign advance = (state_q == RUN) && !redirect_valid && !stall_if;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk          (clk),
    .reset        (reset),
    .redirect     (redirect_valid),
    .redirect_pc  (redirect_pc),
    .advance      (advance),
    .pc           (pc),
    .misalign_err (misalign_err)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (redirect_valid) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (state_q == HALT) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (advance) begin
      instr_d = imem_instr;
      ifpc_d  = pc;
      pc4_d   = pc + PC_STEP;
      valid_d = 1'b1;
      if (count_q != 32'hFFFF_FFFF) begin
        count_d = count_q + 32'd1;
      end
      if (imem_instr == HALT_INSTR) begin
        state_d = HALT;
      end
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      instr_q  <= NOP_INSTR;
      ifpc_q   <= 32'h0;
      pc4_q    <= 32'h0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign imem_addr      = pc;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign halted         = halted_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed table, corner
// sequences, then random stimulus against a behavioural fetch model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall_if       (stall_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic [31:0] e_addr, e_instr, e_ifpc, e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
    logic        e_halt, e_mis;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
    reset          = r;
    stall_if       = s;
    redirect_valid = rd;
    redirect_pc    = rp;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, s, rd, input logic [31:0] rp,
                              input logic [31:0] a, i, p, p4, input logic v,
                              input logic [31:0] c, input logic h, m);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rd; t.rpc = rp;
    t.e_addr = a; t.e_instr = i; t.e_ifpc = p; t.e_pc4 = p4;
    t.e_valid = v; t.e_cnt = c; t.e_halt = h; t.e_mis = m;
    return t;
  endfunction

  // Behavioural reference: architectural fetch state advanced one edge at a time.
  logic [31:0] m_pc, m_instr, m_ifpc, m_pc4, m_cnt;
  logic        m_valid, m_halted, m_mis;

  task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] rp);
    logic [31:0] w;
    w = mem[m_pc[9:2]];
    if (r) begin
      m_pc = 0; m_instr = 0; m_ifpc = 0; m_pc4 = 0; m_valid = 0;
      m_halted = 0; m_mis = 0; m_cnt = 0;
    end else if (rd) begin
      m_pc = rp & 32'hFFFF_FFFC;
      m_instr = 0; m_valid = 0; m_halted = 0;
      if (rp % 4 != 0) m_mis = 1;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0;
    end else if (!s) begin
      m_instr = w; m_ifpc = m_pc; m_pc4 = m_pc + 4; m_valid = 1;
      m_pc = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (w == HALT_W) m_halted = 1;
    end
  endtask

  initial begin
    reset = 1'b1; stall_if = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h0022_1820; mem[1] = 32'h0025_3822;
    mem[2] = 32'h0032_9812; mem[3] = 32'h0008_19E5;
    mem[4] = HALT_W;
    mem[16] = 32'h8C01_0004;
    mem[255] = 32'h2002_FFFF;

    //            rst s rd rpc          addr   instr          ifpc   pc4    v cnt h m
    tbl[0]  = mk(1, 0, 0, 0,           0,     0,             0,     0,     0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,           4,     32'h00221820,  0,     4,     1, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,           8,     32'h00253822,  4,     8,     1, 2, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,           12,    32'h00329812,  8,     12,    1, 3, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,           16,    32'h000819E5,  12,    16,    1, 4, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0,           0,     0,             0,     0,     0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,           4,     32'h00221820,  0,     4,     1, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,           8,     32'h00253822,  4,     8,     1, 2, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0,           8,     32'h00253822,  4,     8,     1, 2, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0,           8,     32'h00253822,  4,     8,     1, 2, 0, 0);
    tbl[10] = mk(0, 0, 0, 0,           12,    32'h00329812,  8,     12,    1, 3, 0, 0);
    tbl[11] = mk(0, 1, 1, 32'h40,      32'h40, 0,            8,     12,    0, 3, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,           32'h44, 32'h8C010004, 32'h40, 32'h44, 1, 4, 0, 0);
    tbl[13] = mk(0, 0, 1, 32'h42,      32'h40, 0,            32'h40, 32'h44, 0, 4, 0, 1);
    tbl[14] = mk(0, 0, 1, 32'h08,      8,     0,             32'h40, 32'h44, 0, 4, 0, 1);
    tbl[15] = mk(0, 0, 0, 0,           12,    32'h00329812,  8,     12,    1, 5, 0, 1);
    tbl[16] = mk(0, 0, 0, 0,           16,    32'h000819E5,  12,    16,    1, 6, 0, 1);
    tbl[17] = mk(0, 0, 0, 0,           20,    HALT_W,        16,    20,    1, 7, 1, 1);
    tbl[18] = mk(0, 0, 0, 0,           20,    0,             16,    20,    0, 7, 1, 1);
    tbl[19] = mk(0, 1, 0, 0,           20,    0,             16,    20,    0, 7, 1, 1);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      chk($sformatf("tbl%0d.imem_addr", i),   imem_addr,      tbl[i].e_addr);
      chk($sformatf("tbl%0d.if_id_instr", i), if_id_instr,    tbl[i].e_instr);
      chk($sformatf("tbl%0d.if_id_pc", i),    if_id_pc,       tbl[i].e_ifpc);
      chk($sformatf("tbl%0d.pc_plus4", i),    if_id_pc_plus4, tbl[i].e_pc4);
      chk($sformatf("tbl%0d.valid", i),       32'(if_id_valid),  32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.fetch_count", i), fetch_count,    tbl[i].e_cnt);
      chk($sformatf("tbl%0d.halted", i),      32'(halted),       32'(tbl[i].e_halt));
      chk($sformatf("tbl%0d.misalign", i),    32'(misalign_err), 32'(tbl[i].e_mis));
    end

    // Halt holds the pc regardless of stall.
    for (int i = 0; i < 10; i++) begin
      step(0, 1'($urandom_range(0, 1)), 0, 0);
      chk("halt_hold.addr",   imem_addr, 32'd20);
      chk("halt_hold.valid",  32'(if_id_valid), 32'd0);
      chk("halt_hold.halted", 32'(halted), 32'd1);
      chk("halt_hold.count",  fetch_count, 32'd7);
    end
    step(0, 1, 1, 32'h0);
    chk("halt_exit.addr",   imem_addr, 32'd0);
    chk("halt_exit.halted", 32'(halted), 32'd0);
    chk("halt_exit.valid",  32'(if_id_valid), 32'd0);
    chk("halt_exit.ifpc",   if_id_pc, 32'd16);
    step(0, 0, 0, 0);
    chk("refetch.instr", if_id_instr, 32'h0022_1820);
    chk("refetch.ifpc",  if_id_pc, 32'd0);
    chk("refetch.valid", 32'(if_id_valid), 32'd1);
    chk("refetch.count", fetch_count, 32'd8);
    chk("refetch.mis",   32'(misalign_err), 32'd1);

    // Reset during stall and redirect clears everything.
    step(0, 0, 1, 32'h40);
    step(0, 1, 0, 0);
    chk("pre_rst.addr", imem_addr, 32'h40);
    step(1, 1, 1, 32'h80);
    chk("rst.addr",   imem_addr, 32'd0);
    chk("rst.instr",  if_id_instr, 32'd0);
    chk("rst.ifpc",   if_id_pc, 32'd0);
    chk("rst.pc4",    if_id_pc_plus4, 32'd0);
    chk("rst.valid",  32'(if_id_valid), 32'd0);
    chk("rst.mis",    32'(misalign_err), 32'd0);
    chk("rst.count",  fetch_count, 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);

    // pc+4 wraps at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap.addr1", imem_addr, 32'd0);
    chk("wrap.instr", if_id_instr, 32'h2002_FFFF);
    chk("wrap.ifpc",  if_id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4",   if_id_pc_plus4, 32'd0);

    // Random stimulus against the reference model.
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 11) == 0) ? HALT_W : $urandom;
    step(1, 0, 0, 0);
    model_edge(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, s, rd;
      logic [31:0] rp;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) == 0);
      rp = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 1023));
      model_edge(r, s, rd, rp);
      step(r, s, rd, rp);
      chk("rnd.addr",   imem_addr, m_pc);
      chk("rnd.instr",  if_id_instr, m_instr);
      chk("rnd.ifpc",   if_id_pc, m_ifpc);
      chk("rnd.pc4",    if_id_pc_plus4, m_pc4);
      chk("rnd.valid",  32'(if_id_valid), 32'(m_valid));
      chk("rnd.halted", 32'(halted), 32'(m_halted));
      chk("rnd.mis",    32'(misalign_err), 32'(m_mis));
      chk("rnd.count",  fetch_count, m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
